bcd_countdown_timer: RTL and testbench

Multi-digit BCD down-counter with load, start/pause control and a single-cycle expiry strobe. It is the counting-down counterpart of the team's mod-10 up-counter. Each digit decrements through 9..0 and borrows into the next digit. It sits between a prescaler, which supplies `tick`, and the display/control logic, which consumes `count_out` and `done`.

---
 rtl/bcd_countdown_timer.sv | 121 ++++++++++++
 tb/tb_bcd_countdown_timer.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_countdown_timer.sv
// bcd_countdown_timer: multi-digit BCD down-counter with load, start/pause
// control, a one-cycle expiry strobe and a one-cycle load-reject strobe.
// Digit 0 occupies bits [3:0]; each digit counts 9..0 and borrows upward.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | loaded or expired, ticks ignored, waiting for start
//   RUN   | counting down one BCD step per tick
//   HOLD  | paused mid-count, ticks ignored, start resumes
module bcd_countdown_timer #(
   parameter int DIGITS = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load,
   input  logic [4*DIGITS-1:0]   load_value,
   input  logic                  start,
   input  logic                  pause,
   input  logic                  tick,
   output logic [4*DIGITS-1:0]   count_out,
   output logic                  running,
   output logic                  done,
   output logic                  load_err
);

   localparam int W = 4 * DIGITS;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HOLD = 2'd2
   } state_t;

   state_t         state, state_nxt;
   logic [W-1:0]   count_nxt;
   logic           done_nxt;
   logic           load_err_nxt;
   logic           load_ok;
   logic           count_zero;
   logic [W-1:0]   count_dec;

   // True when every nibble is a legal BCD digit (0..9).
   function automatic logic bcd_valid(input logic [W-1:0] v);
      logic ok;
      ok = 1'b1;
      for (int k = 0; k < DIGITS; k++) begin
         if (v[4*k +: 4] > 4'd9) ok = 1'b0;
      end
      return ok;
   endfunction

   // One BCD decrement: a digit steps down only while every lower digit is
   // zero; a digit that borrows from zero wraps to 9.
   function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
      logic [W-1:0] r;
      logic         borrow;
      r      = v;
      borrow = 1'b1;
      for (int k = 0; k < DIGITS; k++) begin
         if (borrow) begin
            r[4*k +: 4] = (v[4*k +: 4] == 4'd0) ? 4'd9 : (v[4*k +: 4] - 4'd1);
         end
         borrow = borrow & (v[4*k +: 4] == 4'd0);
      end
      return r;
   endfunction

   assign load_ok    = bcd_valid(load_value);
   assign count_zero = (count_out == '0);
   assign count_dec  = bcd_dec(count_out);

   // Next state and next registered outputs; load > start > pause > tick.
   always_comb begin
      state_nxt    = state;
      count_nxt    = count_out;
      done_nxt     = 1'b0;
      load_err_nxt = 1'b0;
      if (load) begin
         if (load_ok) begin
            count_nxt = load_value;
            state_nxt = IDLE;
         end else begin
            load_err_nxt = 1'b1;
         end
      end else if (start) begin
         if (count_zero) begin
            done_nxt = 1'b1;
         end else if (state != RUN) begin
            state_nxt = RUN;
         end
      end else if (pause) begin
         if (state == RUN) state_nxt = HOLD;
      end else if (tick && (state == RUN) && !count_zero) begin
         count_nxt = count_dec;
         // Expiry: the step that lands on zero also leaves RUN.
         if (count_dec == '0) begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
         end
      end
   end

   // State and output registers; running mirrors the next state so it
   // changes on the same edge as the count and done.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         count_out <= '0;
         running   <= 1'b0;
         done      <= 1'b0;
         load_err  <= 1'b0;
      end else begin
         state     <= state_nxt;
         count_out <= count_nxt;
         running   <= (state_nxt == RUN);
         done      <= done_nxt;
         load_err  <= load_err_nxt;
      end
   end

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Directed bench for bcd_countdown_timer (DIGITS=4): run to expiry, borrow
// chain, pause/resume, load priority and rejection, zero start, async reset.
module tb_bcd_countdown_timer;

   logic        clk;
   logic        rst;
   logic        load;
   logic [15:0] load_value;
   logic        start;
   logic        pause;
   logic        tick;
   logic [15:0] count_out;
   logic        running;
   logic        done;
   logic        load_err;

   int checks = 0;
   int errors = 0;

   bcd_countdown_timer #(.DIGITS(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .load       (load),
      .load_value (load_value),
      .start      (start),
      .pause      (pause),
      .tick       (tick),
      .count_out  (count_out),
      .running    (running),
      .done       (done),
      .load_err   (load_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask

   // Decimal to 4-digit BCD, digit 0 in the low nibble.
   function automatic logic [15:0] to_bcd(input int v);
      logic [15:0] r;
      int          x;
      x = v;
      for (int i = 0; i < 4; i++) begin
         r[4*i +: 4] = 4'(x % 10);
         x = x / 10;
      end
      return r;
   endfunction

   // Advance one edge and settle 1 time unit past it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      load = 1'b0; start = 1'b0; pause = 1'b0; tick = 1'b0;
   endtask

   task automatic do_load(input logic [15:0] v);
      idle_inputs();
      load = 1'b1; load_value = v;
      step();
      load = 1'b0;
   endtask

   task automatic do_start();
      idle_inputs();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   initial begin
      rst = 1'b0;
      load_value = 16'h0000;
      idle_inputs();
      step();
      step();
      chk("rst_count", count_out, 16'h0000);
      chk("rst_running", running, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_load_err", load_err, 1'b0);
      rst = 1'b1;
      step();

      // Load 0012 and run to expiry.
      do_load(16'h0012);
      chk("t1_load", count_out, 16'h0012);
      chk("t1_load_running", running, 1'b0);
      do_start();
      chk("t1_start_running", running, 1'b1);
      chk("t1_start_count", count_out, 16'h0012);
      tick = 1'b1;
      for (int v = 11; v >= 1; v--) begin
         step();
         chk("t1_count", count_out, to_bcd(v));
         chk("t1_done_low", done, 1'b0);
         chk("t1_running", running, 1'b1);
      end
      step();
      chk("t1_expire_count", count_out, 16'h0000);
      chk("t1_expire_done", done, 1'b1);
      chk("t1_expire_running", running, 1'b0);
      step();
      chk("t1_done_once", done, 1'b0);
      chk("t1_stay_zero", count_out, 16'h0000);
      tick = 1'b0;

      // Borrow chain across three digits.
      do_load(16'h1000);
      do_start();
      tick = 1'b1;
      step();
      tick = 1'b0;
      chk("t2_borrow", count_out, 16'h0999);
      chk("t2_borrow_running", running, 1'b1);
      do_load(16'h0100);
      chk("t2_load_in_run", count_out, 16'h0100);
      chk("t2_load_stops_run", running, 1'b0);
      do_start();
      tick = 1'b1;
      for (int v = 99; v >= 0; v--) begin
         step();
         chk("t2_count", count_out, to_bcd(v));
      end
      chk("t2_done", done, 1'b1);
      chk("t2_running_low", running, 1'b0);
      step();
      chk("t2_tick101_count", count_out, 16'h0000);
      chk("t2_tick101_done", done, 1'b0);
      tick = 1'b0;

      // Pause with tick held, then resume with a coincident tick.
      do_load(16'h0005);
      do_start();
      tick = 1'b1;
      step();
      step();
      chk("t3_pre_pause", count_out, 16'h0003);
      pause = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         chk("t3_hold_count", count_out, 16'h0003);
         chk("t3_hold_running", running, 1'b0);
      end
      pause = 1'b0;
      start = 1'b1;
      step();
      start = 1'b0;
      chk("t3_resume_no_count", count_out, 16'h0003);
      chk("t3_resume_running", running, 1'b1);
      step();
      chk("t3_c2", count_out, 16'h0002);
      step();
      chk("t3_c1", count_out, 16'h0001);
      chk("t3_c1_done", done, 1'b0);
      step();
      chk("t3_c0", count_out, 16'h0000);
      chk("t3_done", done, 1'b1);
      chk("t3_running_low", running, 1'b0);
      tick = 1'b0;

      // Load beats start; invalid loads are rejected.
      idle_inputs();
      load = 1'b1; start = 1'b1; load_value = 16'h0042;
      step();
      idle_inputs();
      chk("t4_loadstart_count", count_out, 16'h0042);
      chk("t4_loadstart_running", running, 1'b0);
      do_load(16'h00A3);
      chk("t4_bad_err", load_err, 1'b1);
      chk("t4_bad_count", count_out, 16'h0042);
      step();
      chk("t4_err_once", load_err, 1'b0);
      do_start();
      do_load(16'hF000);
      chk("t4_bad_run_err", load_err, 1'b1);
      chk("t4_bad_run_running", running, 1'b1);
      chk("t4_bad_run_count", count_out, 16'h0042);
      pause = 1'b1;
      step();
      pause = 1'b0;
      chk("t4_pause_running", running, 1'b0);

      // Start at zero.
      do_load(16'h0000);
      do_start();
      chk("t5_zero_done", done, 1'b1);
      chk("t5_zero_running", running, 1'b0);
      step();
      chk("t5_zero_done_once", done, 1'b0);

      // Async reset between edges mid-run.
      do_load(16'h0456);
      do_start();
      chk("t6_pre_rst_running", running, 1'b1);
      chk("t6_pre_rst_count", count_out, 16'h0456);
      #2;
      rst = 1'b0;
      #1;
      chk("t6_async_count", count_out, 16'h0000);
      chk("t6_async_running", running, 1'b0);
      step();
      rst = 1'b1;
      step();
      chk("t6_post_count", count_out, 16'h0000);
      chk("t6_post_running", running, 1'b0);
      chk("t6_post_done", done, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
